// File: rtl/wb_regfile.sv
// wb_regfile: write-back select, 32-entry integer register file with two
// combinational decode read ports, same-cycle WB->ID bypass, and a
// free-running count of committed register writes.
//
// Port names follow the pipeline's MEM/WB naming rather than i_/o_ prefixes
// so the block drops straight into the existing stage wiring.

module wb_regfile #(
    parameter int WIDTH = 32,
    parameter int NREGS = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             MEMTOREG_IN,
    input  logic             REGWRITE_IN,
    input  logic [WIDTH-1:0] MEMDATA_IN,
    input  logic [WIDTH-1:0] RESULTOP_IN,
    input  logic [4:0]       ARD_IN,
    input  logic [4:0]       ARS1_IN,
    input  logic [4:0]       ARS2_IN,
    output logic [WIDTH-1:0] RS1_DATA_OUT,
    output logic [WIDTH-1:0] RS2_DATA_OUT,
    output logic [WIDTH-1:0] WBDATA_OUT,
    output logic [31:0]      WBCOUNT_OUT
);

    // Entry 0 is x0 and is never stored; reads of it are forced to zero.
    logic [WIDTH-1:0] r_regs [1:NREGS-1];
    logic [31:0]      r_wbcount;

    logic [WIDTH-1:0] w_wbdata;
    logic             w_we;
    logic [WIDTH-1:0] w_rs1_arr;
    logic [WIDTH-1:0] w_rs2_arr;
    logic             w_rs1_byp;
    logic             w_rs2_byp;

    // Write-back value select; driven regardless of the write enable because
    // the EX forwarding mux consumes it too.
    always_comb begin
        w_wbdata = MEMTOREG_IN ? MEMDATA_IN : RESULTOP_IN;
    end

    // Commit enable. Deliberately independent of rst so the bypass keeps
    // working while reset is held; the storage itself ignores it in reset.
    always_comb begin
        w_we = REGWRITE_IN && (ARD_IN != 5'd0);
    end

    // Register array commit. Addresses that do not map to an implemented
    // entry (only possible when NREGS < 32) simply match nothing.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 1; i < NREGS; i++) begin
                r_regs[i] <= '0;
            end
        end else begin
            for (int i = 1; i < NREGS; i++) begin
                if (w_we && (ARD_IN == 5'(i))) begin
                    r_regs[i] <= w_wbdata;
                end
            end
        end
    end

    // Committed-write counter; wraps silently at 2^32.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_wbcount <= '0;
        end else if (w_we) begin
            r_wbcount <= r_wbcount + 32'd1;
        end
    end

    // Array lookup for both read ports, decoded as a one-hot compare so an
    // unimplemented address reads as zero.
    always_comb begin
        w_rs1_arr = '0;
        w_rs2_arr = '0;
        for (int i = 1; i < NREGS; i++) begin
            if (ARS1_IN == 5'(i)) begin
                w_rs1_arr = r_regs[i];
            end
            if (ARS2_IN == 5'(i)) begin
                w_rs2_arr = r_regs[i];
            end
        end
    end

    // Bypass detection: a write landing this cycle on the register being read.
    always_comb begin
        w_rs1_byp = w_we && (ARS1_IN == ARD_IN);
        w_rs2_byp = w_we && (ARS2_IN == ARD_IN);
    end

    // Final read mux per port: x0, then bypass, then array.
    always_comb begin
        if (ARS1_IN == 5'd0) begin
            RS1_DATA_OUT = '0;
        end else if (w_rs1_byp) begin
            RS1_DATA_OUT = w_wbdata;
        end else begin
            RS1_DATA_OUT = w_rs1_arr;
        end

        if (ARS2_IN == 5'd0) begin
            RS2_DATA_OUT = '0;
        end else if (w_rs2_byp) begin
            RS2_DATA_OUT = w_wbdata;
        end else begin
            RS2_DATA_OUT = w_rs2_arr;
        end
    end

    assign WBDATA_OUT  = w_wbdata;
    assign WBCOUNT_OUT = r_wbcount;

endmodule

// File: tb/tb_wb_regfile.sv
// Testbench for wb_regfile: directed vector table, hand-written reset
// sequences, and randomized traffic against an array-based reference model.

module tb_wb_regfile;

    logic        clk;
    logic        rst;
    logic        MEMTOREG_IN;
    logic        REGWRITE_IN;
    logic [31:0] MEMDATA_IN;
    logic [31:0] RESULTOP_IN;
    logic [4:0]  ARD_IN;
    logic [4:0]  ARS1_IN;
    logic [4:0]  ARS2_IN;
    logic [31:0] RS1_DATA_OUT;
    logic [31:0] RS2_DATA_OUT;
    logic [31:0] WBDATA_OUT;
    logic [31:0] WBCOUNT_OUT;

    int n_checks = 0;
    int n_fail   = 0;

    wb_regfile #(.WIDTH(32), .NREGS(32)) dut (
        .clk          (clk),
        .rst          (rst),
        .MEMTOREG_IN  (MEMTOREG_IN),
        .REGWRITE_IN  (REGWRITE_IN),
        .MEMDATA_IN   (MEMDATA_IN),
        .RESULTOP_IN  (RESULTOP_IN),
        .ARD_IN       (ARD_IN),
        .ARS1_IN      (ARS1_IN),
        .ARS2_IN      (ARS2_IN),
        .RS1_DATA_OUT (RS1_DATA_OUT),
        .RS2_DATA_OUT (RS2_DATA_OUT),
        .WBDATA_OUT   (WBDATA_OUT),
        .WBCOUNT_OUT  (WBCOUNT_OUT)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        m2r;
        logic        rw;
        logic [31:0] mem;
        logic [31:0] res;
        logic [4:0]  ard;
        logic [4:0]  ars1;
        logic [4:0]  ars2;
        logic [31:0] e_rs1;
        logic [31:0] e_rs2;
        logic [31:0] e_wb;
        logic [31:0] e_cnt;
    } vec_t;

    vec_t vecs [12];

    // Reference model state
    logic [31:0] m_regs [32];
    logic [31:0] m_cnt;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s actual=%h required=%h at t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic drive(input logic m2r, input logic rw, input logic [31:0] mem,
                         input logic [31:0] res, input logic [4:0] ard,
                         input logic [4:0] ars1, input logic [4:0] ars2);
        MEMTOREG_IN = m2r;
        REGWRITE_IN = rw;
        MEMDATA_IN  = mem;
        RESULTOP_IN = res;
        ARD_IN      = ard;
        ARS1_IN     = ars1;
        ARS2_IN     = ars2;
    endtask

    function automatic logic [31:0] model_read(input logic [4:0] ars, input logic we,
                                               input logic [4:0] ard, input logic [31:0] wb);
        if (ars == 5'd0) return 32'd0;
        if (we && ars == ard) return wb;
        return m_regs[ars];
    endfunction

    initial begin
        // Directed vectors; expected outputs are the pre-edge combinational
        // values and the count accumulated by earlier edges.
        //            m2r rw  mem           res           ard    ars1   ars2   rs1           rs2           wb            cnt
        vecs[0]  = '{1'b0,1'b1,32'h0,        32'h12345678,5'd21, 5'd21, 5'd1,  32'h12345678,32'h0,        32'h12345678,32'd0};
        vecs[1]  = '{1'b0,1'b0,32'h0,        32'h0,       5'd0,  5'd21, 5'd21, 32'h12345678,32'h12345678,32'h0,       32'd1};
        vecs[2]  = '{1'b1,1'b1,32'hDEADBEEF, 32'h11111111,5'd14, 5'd14, 5'd14, 32'hDEADBEEF,32'hDEADBEEF,32'hDEADBEEF,32'd1};
        vecs[3]  = '{1'b0,1'b0,32'h0,        32'h0,       5'd0,  5'd14, 5'd21, 32'hDEADBEEF,32'h12345678,32'h0,       32'd2};
        vecs[4]  = '{1'b0,1'b1,32'h0,        32'hFFFFFFFF,5'd0,  5'd0,  5'd14, 32'h0,       32'hDEADBEEF,32'hFFFFFFFF,32'd2};
        vecs[5]  = '{1'b0,1'b0,32'h0,        32'h87654321,5'd21, 5'd0,  5'd21, 32'h0,       32'h12345678,32'h87654321,32'd2};
        vecs[6]  = '{1'b0,1'b0,32'h0,        32'h0,       5'd0,  5'd21, 5'd0,  32'h12345678,32'h0,       32'h0,       32'd2};
        vecs[7]  = '{1'b0,1'b1,32'h0,        32'hAAAA0001,5'd5,  5'd5,  5'd6,  32'hAAAA0001,32'h0,       32'hAAAA0001,32'd2};
        vecs[8]  = '{1'b0,1'b1,32'h0,        32'hAAAA0002,5'd5,  5'd5,  5'd5,  32'hAAAA0002,32'hAAAA0002,32'hAAAA0002,32'd3};
        vecs[9]  = '{1'b0,1'b0,32'h0,        32'h0,       5'd0,  5'd5,  5'd31, 32'hAAAA0002,32'h0,       32'h0,       32'd4};
        vecs[10] = '{1'b1,1'b1,32'h00000031, 32'h0,       5'd31, 5'd31, 5'd5,  32'h00000031,32'hAAAA0002,32'h00000031,32'd4};
        vecs[11] = '{1'b0,1'b0,32'h0,        32'h0,       5'd0,  5'd31, 5'd14, 32'h00000031,32'hDEADBEEF,32'h0,       32'd5};

        // Asynchronous reset before any clock edge
        rst = 1'b1;
        drive(1'b0, 1'b0, 32'h0, 32'h0, 5'd0, 5'd0, 5'd0);
        #2 rst = 1'b0;
        #1;
        for (int a = 1; a < 32; a++) begin
            ARS1_IN = 5'(a);
            ARS2_IN = 5'(32 - a);
            #0.1;
            chk("reset_rs1", RS1_DATA_OUT, 32'h0);
            chk("reset_rs2", RS2_DATA_OUT, 32'h0);
        end
        chk("reset_cnt", WBCOUNT_OUT, 32'h0);

        @(negedge clk);
        rst = 1'b1;
        ARS1_IN = 5'd21;
        ARS2_IN = 5'd14;
        @(negedge clk);
        #1;
        chk("post_reset_rs1", RS1_DATA_OUT, 32'h0);
        chk("post_reset_rs2", RS2_DATA_OUT, 32'h0);
        chk("post_reset_cnt", WBCOUNT_OUT, 32'h0);

        // Vector table
        for (int v = 0; v < 12; v++) begin
            @(negedge clk);
            drive(vecs[v].m2r, vecs[v].rw, vecs[v].mem, vecs[v].res,
                  vecs[v].ard, vecs[v].ars1, vecs[v].ars2);
            #1;
            chk($sformatf("vec%0d_rs1", v), RS1_DATA_OUT, vecs[v].e_rs1);
            chk($sformatf("vec%0d_rs2", v), RS2_DATA_OUT, vecs[v].e_rs2);
            chk($sformatf("vec%0d_wb",  v), WBDATA_OUT,   vecs[v].e_wb);
            chk($sformatf("vec%0d_cnt", v), WBCOUNT_OUT,  vecs[v].e_cnt);
        end

        // Mid-run reset with a write pending in the same cycle
        @(negedge clk);
        drive(1'b0, 1'b1, 32'h0, 32'h5A5A5A5A, 5'd3, 5'd3, 5'd21);
        #1 rst = 1'b0;
        #1;
        chk("midrst_bypass", RS1_DATA_OUT, 32'h5A5A5A5A);
        chk("midrst_array",  RS2_DATA_OUT, 32'h0);
        chk("midrst_cnt",    WBCOUNT_OUT,  32'h0);
        @(posedge clk);
        #1;
        REGWRITE_IN = 1'b0;
        #1;
        chk("midrst_noWrite", RS1_DATA_OUT, 32'h0);
        chk("midrst_cnt2",    WBCOUNT_OUT,  32'h0);
        @(negedge clk);
        rst = 1'b1;
        drive(1'b0, 1'b1, 32'h0, 32'h0BADF00D, 5'd3, 5'd14, 5'd31);
        #1;
        chk("rel_rs1", RS1_DATA_OUT, 32'h0);
        chk("rel_rs2", RS2_DATA_OUT, 32'h0);
        @(negedge clk);
        drive(1'b0, 1'b0, 32'h0, 32'h0, 5'd0, 5'd3, 5'd5);
        #1;
        chk("first_write", RS1_DATA_OUT, 32'h0BADF00D);
        chk("first_cnt",   WBCOUNT_OUT,  32'd1);
        chk("cleared_r5",  RS2_DATA_OUT, 32'h0);

        // Randomized traffic vs reference model
        for (int r = 0; r < 32; r++) m_regs[r] = 32'h0;
        m_regs[3] = 32'h0BADF00D;
        m_cnt = 32'd1;
        for (int cyc = 0; cyc < 600; cyc++) begin
            logic        m2r, rw, we, do_rst;
            logic [31:0] mem, res, wb;
            logic [4:0]  ard, a1, a2;
            @(negedge clk);
            m2r = 1'($urandom_range(0, 1));
            rw  = ($urandom_range(0, 3) != 0);
            mem = $urandom;
            res = $urandom;
            ard = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom_range(0, 31));
            a1  = ($urandom_range(0, 3) == 0) ? ard : 5'($urandom_range(0, 31));
            a2  = ($urandom_range(0, 3) == 0) ? a1  : 5'($urandom_range(0, 31));
            do_rst = ($urandom_range(0, 59) == 0);
            drive(m2r, rw, mem, res, ard, a1, a2);
            rst = !do_rst;
            if (do_rst) begin
                for (int r = 0; r < 32; r++) m_regs[r] = 32'h0;
                m_cnt = 32'd0;
            end
            wb = m2r ? mem : res;
            we = rw && (ard != 5'd0);
            #1;
            chk("rnd_rs1", RS1_DATA_OUT, model_read(a1, we, ard, wb));
            chk("rnd_rs2", RS2_DATA_OUT, model_read(a2, we, ard, wb));
            chk("rnd_wb",  WBDATA_OUT,   wb);
            chk("rnd_cnt", WBCOUNT_OUT,  m_cnt);
            @(posedge clk);
            if (!do_rst && we) begin
                m_regs[ard] = wb;
                m_cnt = m_cnt + 32'd1;
            end
        end

        @(negedge clk);
        rst = 1'b1;
        REGWRITE_IN = 1'b0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/wb_regfile.md
# wb_regfile

Write-back stage and integer register file of the 5-stage pipeline. Consumes the MEM/WB pipeline register outputs, selects the write-back value (memory data or ALU result), commits it to a 32 x WIDTH register array, and serves the two decode-stage read ports. Same-cycle internal bypass removes the WB→ID hazard. The block also keeps a free-running count of committed writes for debug and performance monitoring.

## Interface
- WIDTH, 32, data width of registers and data paths
- NREGS, 32, number of architectural registers; address width is fixed at 5 bits

- clk  in  1  rising-edge clock
- rst  in  1  asynchronous, active-low reset
- MEMTOREG_IN  in  1  from MEM/WB register; 1 = write back MEMDATA_IN, 0 = write back RESULTOP_IN
- REGWRITE_IN  in  1  from MEM/WB register; write enable
- MEMDATA_IN  in  WIDTH  load data from MEM/WB register
- RESULTOP_IN  in  WIDTH  ALU result from MEM/WB register
- ARD_IN  in  5  destination register address
- ARS1_IN  in  5  decode read address, port 1
- ARS2_IN  in  5  decode read address, port 2
- RS1_DATA_OUT  out  WIDTH  read data, port 1 (combinational)
- RS2_DATA_OUT  out  WIDTH  read data, port 2 (combinational)
- WBDATA_OUT  out  WIDTH  selected write-back value (combinational), also used by the EX forwarding mux
- WBCOUNT_OUT  out  32  number of committed register writes (registered)

## Operation
- Write-back mux: WBDATA_OUT = MEMTOREG_IN ? MEMDATA_IN : RESULTOP_IN. Always driven, independent of REGWRITE_IN.
- Commit condition: `we = REGWRITE_IN && (ARD_IN != 0)`.
- When `we` is high, the array entry at ARD_IN <= WBDATA_OUT on the rising clk edge.
- Register x0 is hard-wired to zero. Writes to x0 are discarded and do not increment WBCOUNT_OUT.
- Read port n, evaluated per port:
  - ARSn_IN == 0 → 0.
  - else if `we` and ARSn_IN == ARD_IN → WBDATA_OUT (bypass).
  - else → array[ARSn_IN].
- Both ports may address the same register, and both may hit the bypass in the same cycle.
- WBCOUNT_OUT increments by 1 on each edge where `we` is high. It wraps from FFFFFFFF to 00000000 with no flag.
- Only entries 1..NREGS-1 are storage. Entry 0 need not be implemented.

## Timing
- Reset (rst = 0, asynchronous): all array entries clear to 0 and WBCOUNT_OUT clears to 0 immediately, without waiting for a clock edge.
  - While rst is held low, writes are blocked.
  - Read ports return 0 from the array, but the bypass path stays combinational and still returns WBDATA_OUT when `we` and the address matches.
- Reset deassertion: the first write takes effect on the first rising edge with rst = 1.
- Write latency: 1 cycle.
  - A value written at edge N is readable from the array from edge N onward.
  - In the cycle before edge N it is visible only through the bypass.
- Read latency: 0 cycles (combinational from ARSn_IN, the array, and the WB inputs).
- Reset mid-operation: a pending write in the same cycle as the rst falling edge is lost. WBCOUNT_OUT shows 0, not the incremented value.
- Back-to-back writes to the same register: the last one wins. Each write counts separately.
- No stall or handshake. A write is committed every cycle the enable is valid, so the MEM/WB register must present a bubble (REGWRITE_IN = 0) when the pipeline stalls.

## Test plan
- Reset:
  - Drive rst = 0 with no clock edge → RS1/RS2 read 0 for ARS = 1..31 and WBCOUNT_OUT = 0.
  - Release rst → values remain 0 until the first write.
- ALU write-back:
  - Drive REGWRITE_IN = 1, MEMTOREG_IN = 0, RESULTOP_IN = 12345678, ARD_IN = 10101, then clock.
  - Next cycle, with REGWRITE_IN = 0 and ARS1_IN = 10101 → RS1_DATA_OUT = 12345678 and WBCOUNT_OUT = 1.
- Load write-back and bypass:
  - Drive MEMTOREG_IN = 1, MEMDATA_IN = DEADBEEF, ARD_IN = 01110, REGWRITE_IN = 1, ARS1_IN = ARS2_IN = 01110, before the edge.
  - Required: both read ports = DEADBEEF and WBDATA_OUT = DEADBEEF in the same cycle.
  - After the edge with REGWRITE_IN = 0, the array value is still DEADBEEF.
- x0 protection:
  - Write FFFFFFFF to ARD_IN = 0 with REGWRITE_IN = 1.
  - Required: RS1 at ARS1_IN = 0 reads 0 both during and after the write, and WBCOUNT_OUT does not change.
- Write-enable gating:
  - Drive REGWRITE_IN = 0 with RESULTOP_IN = 87654321 and ARD_IN = 10101.
  - Required: WBDATA_OUT = 87654321, register 10101 keeps 12345678, and WBCOUNT_OUT does not change.
- Mid-run reset:
  - After several writes, pulse rst low between edges.
  - Required: all registers read 0 and WBCOUNT_OUT = 0 immediately, before the next edge.
